ysyx_22050243_lsu: RTL and testbench
====================================

# ysyx_22050243_lsu

Load/store unit that turns one pipeline memory operation into the data-memory request bus: `data_w_en`, `data_r_en`, `data_wmask`, `data_addr`, `data_w` out, and `data_r` back. It sits between EXU and the data memory, and hands the result to WBU over a valid/ready handshake.

- Stores: byte lanes and write mask are aligned before issue.
- Loads: returned data is shifted and sign- or zero-extended.

## Interface
- No parameters. Data width is fixed at 64 bits and memory word size at 8 bytes.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: EXU presents an operation.
- `in_ready` out 1: LSU can accept an operation.
- `in_wen` in 1: 1 = store, 0 = load.
- `in_size` in 3: bits[1:0] select size (00 = B, 01 = H, 10 = W, 11 = D); bit 2 selects unsigned load (ignored for stores).
- `in_addr` in 64: byte address.
- `in_wdata` in 64: store data, right-justified.
- `in_rd` in 5: destination register of a load.
- `out_valid` out 1: result available.
- `out_ready` in 1: WBU accepts the result.
- `out_rdata` out 64: extended load data; 0 for stores.
- `out_rd` out 5: latched `in_rd` for loads; 0 for stores.
- `out_misalign` out 1: access was misaligned and was not performed.
- `data_w_en` out 1, `data_r_en` out 1: memory write / read enable.
- `data_wmask` out 8: byte enables.
- `data_addr` out 64: 8-byte-aligned address.
- `data_w` out 64: lane-shifted store data.
- `data_r` in 64: combinational read data from memory, valid in the same cycle as `data_r_en`.

## Operation
FSM with three states:
- **IDLE**
  - `in_ready` = 1.
  - When `in_valid` = 1, latch `wen`, `size`, `addr`, `wdata` and `rd`, then go to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - `data_addr` = {addr[63:3], 3'b0}. `off` = addr[2:0].
  - Base mask is 0x01, 0x03, 0x0F or 0xFF for B/H/W/D. `data_wmask` = (base mask << `off`), truncated to 8 bits.
  - `data_w` = `wdata` << (8·`off`).
  - Store: `data_w_en` = 1.
  - Load: `data_r_en` = 1. Capture (`data_r` >> 8·`off`), truncate to size, then sign-extend (bit 2 = 0) or zero-extend (bit 2 = 1) into the result register.
  - Then go to DONE.
- **DONE**
  - `out_valid` = 1; outputs are held stable.
  - Go to IDLE in the cycle `out_ready` = 1.
- `data_w_en`, `data_r_en`, `data_wmask`, `data_addr` and `data_w` are 0 in every state other than ACCESS.
- `in_ready` is 0 in ACCESS and DONE, so there is no second outstanding operation.
- Misalignment: `off` is not a multiple of the access size (H with off[0]; W with off[1:0] ≠ 0; D with `off` ≠ 0).
  - Handling depends on the configuration below.
- Reset mid-operation: return to IDLE immediately. Any ACCESS cycle in progress is abandoned: enables drop asynchronously and no memory write takes effect on the following edge.

## Timing
- Reset values:
  - state = IDLE, `in_ready` = 1.
  - `out_valid`, `out_misalign`, `data_w_en`, `data_r_en` = 0.
  - `data_wmask` = 0, `data_addr` = 0, `data_w` = 0, `out_rdata` = 0, `out_rd` = 0.
- Accept at edge N (IDLE, `in_valid`), ACCESS during cycle N+1, `out_valid` from cycle N+2.
- Minimum 3 cycles per operation.
- The memory commits a store at the edge that ends ACCESS.
- Load data is registered at that same edge, so `out_rdata` is valid from the first DONE cycle.
- `out_valid` with `out_ready` held at 0: hold indefinitely with no change in outputs.
- `in_valid` is ignored outside IDLE; the EXU must hold its operation until it sees `in_ready`.

## Configuration
- `YSYX_22050243_LSU_MISALIGN_CHECK_EN`
  - **Defined:** a misaligned operation still passes through ACCESS with all memory enables at 0. DONE reports `out_misalign` = 1, `out_rdata` = 0 and `out_rd` = latched rd.
  - **Undefined:** no check. `out_misalign` is tied to 0 and every access is issued using the mask and shift rules above; mask bits shifted past bit 7 are dropped.

## Test plan
- **SD aligned:** SD addr 0x80000010, wdata 0x1122334455667788 -> one ACCESS cycle with `data_w_en` = 1, `data_addr` 0x80000010, `data_wmask` 0xFF, `data_w` 0x1122334455667788; then `out_valid` with `out_rdata` 0.
- **SB lane shift:** SB addr 0x80000005, wdata 0xAB -> `data_wmask` 0x20, `data_w` 0x0000AB0000000000, `data_addr` 0x80000000.
- **LB vs LBU sign/zero extension:** memory word 0x00000000_0000F000, addr 0x80000001, rd 7 -> LB gives `out_rdata` 0xFFFFFFFFFFFFFFF0 and `out_rd` 7; LBU gives 0x00000000000000F0.
- **Stalled consumer:** LW with `out_ready` held 0 for 5 cycles -> `out_valid` and `out_rdata` stable, `in_ready` 0, and a new `in_valid` is ignored until the DONE→IDLE handshake.
- **Misaligned access:** LW addr 0x80000002 -> with the macro defined, no `data_r_en` and `out_misalign` = 1; without it, `data_r_en` = 1 and `out_misalign` = 0.
- **Reset during ACCESS:** assert `rst` in ACCESS of an SD -> `data_w_en` goes to 0 immediately, memory is unchanged, state is IDLE and `in_ready` = 1 after release.

Source files
------------

// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu: load/store unit. Three-state IDLE/ACCESS/DONE sequencer, 64-bit data, 8-byte words.
// Optional misalignment trap enabled by defining YSYX_22050243_LSU_MISALIGN_CHECK_EN.
`default_nettype none

module ysyx_22050243_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_size,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_misalign,
  output logic        data_w_en,
  output logic        data_r_en,
  output logic [7:0]  data_wmask,
  output logic [63:0] data_addr,
  output logic [63:0] data_w,
  input  logic [63:0] data_r
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        wen_q, wen_d;
  logic [2:0]  size_q, size_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] rdata_q, rdata_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        misalign_q, misalign_d;

  logic [2:0]  off;
  logic [5:0]  bit_sh;
  logic [7:0]  base_mask;
  logic [63:0] shifted;
  logic [63:0] load_ext;
  logic        misalign;

  assign off    = addr_q[2:0];
  assign bit_sh = {off, 3'b000};

  always_comb begin
    base_mask = 8'h01;
    case (size_q[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

`ifdef YSYX_22050243_LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (size_q[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      2'b10:   misalign = |off[1:0];
      default: misalign = |off;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Bring the addressed lane down to bit 0, then extend by size and signedness.
  assign shifted = data_r >> bit_sh;

  always_comb begin
    load_ext = shifted;
    case (size_q[1:0])
      2'b00:   load_ext = size_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = size_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = size_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    out_rd_d   = out_rd_q;
    misalign_d = misalign_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    data_w_en  = 1'b0;
    data_r_en  = 1'b0;
    data_wmask = 8'h00;
    data_addr  = 64'd0;
    data_w     = 64'd0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wen_d   = in_wen;
          size_d  = in_size;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          rd_d    = in_rd;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        data_addr  = {addr_q[63:3], 3'b000};
        data_wmask = base_mask << off;
        data_w     = wdata_q << bit_sh;
        data_w_en  = wen_q & ~misalign;
        data_r_en  = ~wen_q & ~misalign;
        rdata_d    = (wen_q | misalign) ? 64'd0 : load_ext;
        // A trapped access still reports its rd so WBU can attribute the fault.
        out_rd_d   = (wen_q & ~misalign) ? 5'd0 : rd_q;
        misalign_d = misalign;
        state_d    = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wen_q      <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      rd_q       <= 5'd0;
      rdata_q    <= 64'd0;
      out_rd_q   <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      out_rd_q   <= out_rd_d;
      misalign_q <= misalign_d;
    end
  end

  assign out_rdata    = rdata_q;
  assign out_rd       = out_rd_q;
  assign out_misalign = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050243_lsu.sv
// Directed bench for ysyx_22050243_lsu with a byte-masked 16-word memory model.
`default_nettype none

module tb_ysyx_22050243_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen = 1'b0;
  logic [2:0]  in_size = 3'd0;
  logic [63:0] in_addr = 64'd0;
  logic [63:0] in_wdata = 64'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_misalign;
  logic        data_w_en;
  logic        data_r_en;
  logic [7:0]  data_wmask;
  logic [63:0] data_addr;
  logic [63:0] data_w;
  logic [63:0] data_r;

  logic [63:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [63:0] pre_val = 64'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22050243_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_misalign(out_misalign),
    .data_w_en(data_w_en), .data_r_en(data_r_en), .data_wmask(data_wmask),
    .data_addr(data_addr), .data_w(data_w), .data_r(data_r)
  );

  assign data_r = mem[data_addr[6:3]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (data_w_en) begin
      for (int b = 0; b < 8; b++) begin
        if (data_wmask[b]) mem[data_addr[6:3]][8*b +: 8] <= data_w[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        pre;
    logic [63:0] pre_val;
    logic [7:0]  e_mask;
    logic [63:0] e_addr;
    logic [63:0] e_w;
    logic        e_wen;
    logic        e_ren;
    logic [63:0] e_rdata;
    logic [4:0]  e_rd;
    logic        e_mis;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [63:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Drive one operation at a negedge; returns at the negedge of its ACCESS cycle.
  task automatic issue(input logic wen, input logic [2:0] size, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1; in_wen = wen; in_size = size; in_addr = addr; in_wdata = wdata; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'b011, 64'h80000010, 64'h1122334455667788, 5'd3, 1'b0, 64'd0,
                8'hFF, 64'h80000010, 64'h1122334455667788, 1'b1, 1'b0, 64'd0, 5'd0, 1'b0};
    vecs[1] = '{1'b1, 3'b000, 64'h80000005, 64'hAB, 5'd3, 1'b0, 64'd0,
                8'h20, 64'h80000000, 64'h0000AB0000000000, 1'b1, 1'b0, 64'd0, 5'd0, 1'b0};
    vecs[2] = '{1'b0, 3'b000, 64'h80000001, 64'd0, 5'd7, 1'b1, 64'h000000000000F000,
                8'h02, 64'h80000000, 64'd0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF0, 5'd7, 1'b0};
    vecs[3] = '{1'b0, 3'b100, 64'h80000001, 64'd0, 5'd7, 1'b1, 64'h000000000000F000,
                8'h02, 64'h80000000, 64'd0, 1'b0, 1'b1, 64'h00000000000000F0, 5'd7, 1'b0};
    vecs[4] = '{1'b0, 3'b001, 64'h80000006, 64'd0, 5'd10, 1'b1, 64'h8001000000000000,
                8'hC0, 64'h80000000, 64'd0, 1'b0, 1'b1, 64'hFFFFFFFFFFFF8001, 5'd10, 1'b0};
    vecs[5] = '{1'b0, 3'b110, 64'h80000004, 64'd0, 5'd11, 1'b1, 64'hDEADBEEF00000000,
                8'hF0, 64'h80000000, 64'd0, 1'b0, 1'b1, 64'h00000000DEADBEEF, 5'd11, 1'b0};
    vecs[6] = '{1'b0, 3'b011, 64'h80000008, 64'd0, 5'd12, 1'b1, 64'h0123456789ABCDEF,
                8'hFF, 64'h80000008, 64'd0, 1'b0, 1'b1, 64'h0123456789ABCDEF, 5'd12, 1'b0};
    vecs[7] = '{1'b1, 3'b001, 64'h80000002, 64'h1234, 5'd13, 1'b0, 64'd0,
                8'h0C, 64'h80000000, 64'h0000000012340000, 1'b1, 1'b0, 64'd0, 5'd0, 1'b0};
    vecs[8] = '{1'b0, 3'b011, 64'h80000010, 64'd0, 5'd14, 1'b0, 64'd0,
                8'hFF, 64'h80000010, 64'd0, 1'b0, 1'b1, 64'h1122334455667788, 5'd14, 1'b0};
`ifdef YSYX_22050243_LSU_MISALIGN_CHECK_EN
    vecs[9] = '{1'b0, 3'b010, 64'h80000002, 64'd0, 5'd9, 1'b1, 64'hAABBCCDD11223344,
                8'h3C, 64'h80000000, 64'd0, 1'b0, 1'b0, 64'd0, 5'd9, 1'b1};
`else
    vecs[9] = '{1'b0, 3'b010, 64'h80000002, 64'd0, 5'd9, 1'b1, 64'hAABBCCDD11223344,
                8'h3C, 64'h80000000, 64'd0, 1'b0, 1'b1, 64'hFFFFFFFFCCDD1122, 5'd9, 1'b0};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_misalign", out_misalign, 0);
    chk("rst_w_en", data_w_en, 0);
    chk("rst_r_en", data_r_en, 0);
    chk("rst_wmask", data_wmask, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_data_w", data_w, 0);
    chk("rst_rdata", out_rdata, 0);
    chk("rst_rd", out_rd, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre) preload(vecs[i].addr[6:3], vecs[i].pre_val);
      issue(vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
      chk($sformatf("v%0d_acc_in_ready", i), in_ready, 0);
      chk($sformatf("v%0d_acc_out_valid", i), out_valid, 0);
      chk($sformatf("v%0d_w_en", i), data_w_en, vecs[i].e_wen);
      chk($sformatf("v%0d_r_en", i), data_r_en, vecs[i].e_ren);
      chk($sformatf("v%0d_wmask", i), data_wmask, vecs[i].e_mask);
      chk($sformatf("v%0d_addr", i), data_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_data_w", i), data_w, vecs[i].e_w);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_rdata", i), out_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_rd", i), out_rd, vecs[i].e_rd);
      chk($sformatf("v%0d_misalign", i), out_misalign, vecs[i].e_mis);
      chk($sformatf("v%0d_done_w_en", i), data_w_en, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_idle_out_valid", i), out_valid, 0);
    end

    // Stalled consumer: DONE holds while a competing store is ignored
    preload(4'd0, 64'h000000007FFF0001);
    preload(4'd3, 64'h3333);
    issue(1'b0, 3'b010, 64'h80000000, 64'd0, 5'd4);
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b1; in_size = 3'b011; in_addr = 64'h80000018;
    in_wdata = 64'hFFFFFFFFFFFFFFFF; in_rd = 5'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_rdata", out_rdata, 64'h000000007FFF0001);
      chk("stall_rd", out_rd, 5'd4);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_w_en", data_w_en, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_rel_in_ready", in_ready, 1);
    chk("stall_rel_out_valid", out_valid, 0);
    chk("stall_mem_untouched", mem[3], 64'h3333);

    // Reset during the ACCESS cycle of a store
    preload(4'd4, 64'h5555);
    issue(1'b1, 3'b011, 64'h80000020, 64'hCAFEF00DCAFEF00D, 5'd2);
    chk("rstacc_w_en_before", data_w_en, 1);
    rst = 1'b1;
    #1;
    chk("rstacc_w_en_async", data_w_en, 0);
    chk("rstacc_wmask_async", data_wmask, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstacc_in_ready", in_ready, 1);
    chk("rstacc_out_valid", out_valid, 0);
    chk("rstacc_mem", mem[4], 64'h5555);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
